hex_scan_capture: RTL and testbench
===================================

Name: hex_scan_capture

Overview:
Receiving end of the multiplexed hex-display scan interface: monitors a digit-index bus and a 4-bit nibble bus and rebuilds the 32-bit display word being scanned. Each digit is debounced against scan transients, collected into a shadow word, and published once all eight digits have been seen. Used as an on-board loopback checker for the display path and as a readback source for display data.

Parameters:
STABLE_CYCLES, 16, consecutive cycles the (index, nibble) pair must hold before the digit is accepted; legal range 2..255.
TIMEOUT_CYCLES, 1048576, cycles without any accepted digit before the partial frame is discarded and stale asserts; must exceed 8*STABLE_CYCLES.

Ports:
clk100MHz  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
an_in  input  3  scanned digit index, 0..7; digit i maps to data bits [4i+3:4i].
seg_in  input  4  hex nibble currently shown at index an_in.
data_out  output  32  last complete reconstructed word; holds between frames.
frame_valid  output  1  one-cycle pulse when data_out is updated.
data_changed  output  1  one-cycle pulse coincident with frame_valid when the new word differs from the previous data_out.
stale  output  1  high from reset until the first frame, and after any timeout, until the next frame_valid.

Behaviour:
- Reset values: data_out=0, frame_valid=0, data_changed=0, stale=1; shadow word=0, seen mask=0, hold and timeout counters=0, FSM=EMPTY.
- Input stage: {an_in, seg_in} registered once (pair_q). Hold counter is cleared to 1 whenever pair_q differs from its previous value, otherwise increments, saturating.
- Accept: a single-cycle accept strobe fires in the cycle the hold counter reaches STABLE_CYCLES. At most one accept per hold; the pair must change before the next accept.
- On accept: shadow nibble[idx] <= nibble; mask[idx] <= 1; timeout counter <= 0. A duplicate index before the frame completes overwrites its nibble, and the mask is unchanged. Scan order is arbitrary.
- FSM:
  - EMPTY: mask==0. Goes to FILL on accept.
  - FILL: goes to EMIT on the accept that makes mask==8'hFF. Goes to EMPTY on timeout.
  - EMIT: lasts one cycle, then returns to EMPTY.
- Entering EMIT (the edge after the completing accept):
  - data_out <= shadow with the completing nibble included.
  - frame_valid=1 during EMIT.
  - data_changed=1 during EMIT when the new word differs from the old data_out.
  - stale <= 0.
  - mask <= 0.
  - Latency: a completing digit held from cycle t raises frame_valid at cycle t+STABLE_CYCLES+1.
- Accept during EMIT: the digit is recorded into the next frame (mask bit set), and the FSM goes to FILL instead of EMPTY.
- Timeout: the counter runs in FILL only. On reaching TIMEOUT_CYCLES without an accept: mask <= 0, stale <= 1, FSM <= EMPTY. data_out is retained and there is no frame_valid. If an accept and timeout occur in the same cycle, the accept wins and no timeout occurs.
- Counter widths: hold counter is $clog2(STABLE_CYCLES+1) bits; timeout counter is $clog2(TIMEOUT_CYCLES+1) bits. Neither counter wraps.
- Reset asserted mid-frame clears all state to reset values on that edge. No partial frame is ever published.

Decomposition:
- Shared constants package holds: DIGITS=8, NIBBLE_W=4, IDX_W=3, DATA_W=32, and FSM state encodings EMPTY/FILL/EMIT.
- One sub-module, scan_debounce: input register, hold counter and accept strobe. It outputs accept, idx and nibble.
- Mask, shadow word, FSM and timeout live in the top level.

Test Plan (bench uses STABLE_CYCLES=4, TIMEOUT_CYCLES=64):
1. Assert reset 3 cycles -> data_out=0, frame_valid=0, data_changed=0, stale=1; no pulses for 100 idle cycles.
2. Scan indices 0..7 with nibbles of 32'h00123456, each held 8 cycles -> exactly one frame_valid, data_out=32'h00123456, data_changed=1, stale=0. frame_valid occurs at hold start of index 7 + 5 cycles.
3. Repeat the identical scan -> frame_valid=1, data_changed=0, data_out unchanged. Then scan 32'h00123457 -> frame_valid=1 and data_changed=1.
4. Glitch: index 2 held 3 cycles with nibble F, then index 2 held 8 cycles with nibble 4, remaining indices normal -> nibble 2 of data_out=4. Separately, omit the proper index-2 hold -> no frame_valid.
5. Scan indices 0..4, then hold an_in/seg_in constant for 80 cycles -> stale=1, no frame_valid, data_out retained. A following full scan of 32'h00235959 -> frame_valid=1, data_out=32'h00235959, stale=0.
6. Order/duplicate/reset:
   - Scan order 7,3,3(value 7 after 5),0,1,2,4,5,6 -> nibble 3=7, one frame_valid.
   - Then scan 4 digits and assert reset -> all outputs return to reset values, and no frame_valid fires.

Source files
------------

// File: rtl/hex_scan_capture_pkg.sv
// Shared constants, state encoding and a nibble-insert helper for the
// hex display scan capture block.
package hex_scan_capture_pkg;

  localparam int DIGITS   = 8;
  localparam int NIBBLE_W = 4;
  localparam int IDX_W    = 3;
  localparam int DATA_W   = 32;
  localparam int PAIR_W   = IDX_W + NIBBLE_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Return word with the nibble at digit position idx replaced.
  function automatic logic [DATA_W-1:0] put_nibble(
    input logic [DATA_W-1:0]   word,
    input logic [IDX_W-1:0]    idx,
    input logic [NIBBLE_W-1:0] nib
  );
    logic [DATA_W-1:0] r;
    r = word;
    r[int'(idx) * NIBBLE_W +: NIBBLE_W] = nib;
    return r;
  endfunction

endpackage

// File: rtl/hex_scan_capture_debounce.sv
// scan_debounce: registers the (index, nibble) pair, measures how long it
// has been stable and emits one accept strobe per stable hold.
module scan_debounce
  import hex_scan_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [IDX_W-1:0]    i_an,
  input  logic [NIBBLE_W-1:0] i_seg,
  output logic                o_accept,
  output logic [IDX_W-1:0]    o_idx,
  output logic [NIBBLE_W-1:0] o_nibble
);

  localparam int HOLD_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(STABLE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE    = HOLD_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  logic [PAIR_W-1:0] r_pair_q;
  logic [HOLD_W-1:0] r_hold;
  logic              r_accept;
  logic [PAIR_W-1:0] w_pair_in;
  logic              w_changed;

  assign w_pair_in = {i_an, i_seg};
  assign w_changed = (w_pair_in != r_pair_q);

  // Sample the pair, count its hold length (saturating at the target) and
  // raise accept exactly in the cycle the count first reaches the target.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (i_reset) begin
      r_pair_q <= '0;
      r_hold   <= '0;
      r_accept <= 1'b0;
    end else begin
      r_pair_q <= w_pair_in;
      if (w_changed) begin
        r_hold   <= HOLD_ONE;
        r_accept <= 1'b0;
      end else if (r_hold != HOLD_TARGET) begin
        r_hold   <= r_hold + HOLD_ONE;
        r_accept <= (r_hold == HOLD_PRE);
      end else begin
        r_accept <= 1'b0;
      end
    end
  end

  assign o_accept = r_accept;
  assign o_idx    = r_pair_q[PAIR_W-1:NIBBLE_W];
  assign o_nibble = r_pair_q[NIBBLE_W-1:0];

endmodule

// File: rtl/hex_scan_capture.sv
// hex_scan_capture: rebuilds the 32-bit word scanned onto a multiplexed hex
// display from debounced (index, nibble) samples and publishes it once all
// eight digits have been seen.
module hex_scan_capture
  import hex_scan_capture_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                clk100MHz,
  input  logic                reset,
  input  logic [IDX_W-1:0]    an_in,
  input  logic [NIBBLE_W-1:0] seg_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                frame_valid,
  output logic                data_changed,
  output logic                stale
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic                w_accept;
  logic [IDX_W-1:0]    w_idx;
  logic [NIBBLE_W-1:0] w_nibble;
  logic [DIGITS-1:0]   w_mask_acc;
  logic [DATA_W-1:0]   w_shadow_acc;
  logic                w_complete;
  logic                w_timeout;

  state_t              r_state;
  logic [DIGITS-1:0]   r_mask;
  logic [DATA_W-1:0]   r_shadow;
  logic [TO_W-1:0]     r_tcnt;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_frame_valid;
  logic                r_data_changed;
  logic                r_stale;

  scan_debounce #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .i_clk    (clk100MHz),
    .i_reset  (reset),
    .i_an     (an_in),
    .i_seg    (seg_in),
    .o_accept (w_accept),
    .o_idx    (w_idx),
    .o_nibble (w_nibble)
  );

  // Mask and shadow as they would look with the current accept applied.
  assign w_mask_acc   = r_mask | (DIGITS'(1) << w_idx);
  assign w_shadow_acc = put_nibble(r_shadow, w_idx, w_nibble);
  assign w_complete   = w_accept && (&w_mask_acc);
  // An accept in the same cycle always beats the timeout.
  assign w_timeout    = (r_state == FILL) && !w_accept && (r_tcnt == TO_LAST);

  // Frame assembly FSM with registered outputs and the FILL-only timeout.
  always_ff @(posedge clk100MHz) begin
    // NOTE: the shadow word is a plain register, not a RAM, so it is reset
    // along with everything else and a stale nibble can never leak out.
    if (reset) begin
      r_state        <= EMPTY;
      r_mask         <= '0;
      r_shadow       <= '0;
      r_tcnt         <= '0;
      r_data_out     <= '0;
      r_frame_valid  <= 1'b0;
      r_data_changed <= 1'b0;
      r_stale        <= 1'b1;
    end else begin
      r_frame_valid  <= 1'b0;
      r_data_changed <= 1'b0;
      if (w_accept) begin
        r_shadow <= w_shadow_acc;
        r_tcnt   <= '0;
      end
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_mask  <= w_mask_acc;
            r_state <= FILL;
          end
        end
        FILL: begin
          if (w_complete) begin
            r_mask         <= '0;
            r_data_out     <= w_shadow_acc;
            r_frame_valid  <= 1'b1;
            r_data_changed <= (w_shadow_acc != r_data_out);
            r_stale        <= 1'b0;
            r_state        <= EMIT;
          end else if (w_accept) begin
            r_mask <= w_mask_acc;
          end else if (w_timeout) begin
            r_mask  <= '0;
            r_stale <= 1'b1;
            r_tcnt  <= '0;
            r_state <= EMPTY;
          end else begin
            r_tcnt <= r_tcnt + TO_ONE;
          end
        end
        EMIT: begin
          // A digit arriving right after the emit starts the next frame.
          if (w_accept) begin
            r_mask  <= w_mask_acc;
            r_state <= FILL;
          end else begin
            r_state <= EMPTY;
          end
        end
        default: begin
          r_mask  <= '0;
          r_state <= EMPTY;
        end
      endcase
    end
  end

  assign data_out     = r_data_out;
  assign frame_valid  = r_frame_valid;
  assign data_changed = r_data_changed;
  assign stale        = r_stale;

endmodule

// File: tb/tb_hex_scan_capture.sv
// Self-checking bench for hex_scan_capture: directed scans plus random
// frames, compared every cycle against a digit-level reference model.
module tb_hex_scan_capture;

  localparam int S = 4;
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  an_in;
  logic [3:0]  seg_in;
  logic [31:0] data_out;
  logic        frame_valid;
  logic        data_changed;
  logic        stale;

  always #5 clk = ~clk;

  hex_scan_capture #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk100MHz    (clk),
    .reset        (reset),
    .an_in        (an_in),
    .seg_in       (seg_in),
    .data_out     (data_out),
    .frame_valid  (frame_valid),
    .data_changed (data_changed),
    .stale        (stale)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fv_count = 0;
  int fv_cyc = -1;
  logic fv_dc = 1'b0;

  // Reference model: digits seen, word collected, published word and flags.
  logic [31:0] m_data, m_word;
  logic [7:0]  m_seen;
  logic        m_fv, m_dc, m_stale;
  logic [6:0]  m_last;
  int          m_run, m_idle;
  logic        m_acc;
  logic [2:0]  m_acc_idx;
  logic [3:0]  m_acc_nib;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_word = '0; m_seen = '0;
    m_fv = 1'b0; m_dc = 1'b0; m_stale = 1'b1;
    m_last = '0; m_run = 0; m_idle = 0; m_acc = 1'b0;
    m_acc_idx = '0; m_acc_nib = '0;
  endtask

  // One clock edge of the reference: a digit accepted in the previous cycle
  // is folded into the frame, then the input pair's stable run is extended.
  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    m_fv = 1'b0;
    m_dc = 1'b0;
    if (m_acc) begin
      m_word[int'(m_acc_idx) * 4 +: 4] = m_acc_nib;
      m_seen[m_acc_idx] = 1'b1;
      m_idle = 0;
      if (m_seen == 8'hFF) begin
        m_dc    = (m_word != m_data);
        m_data  = m_word;
        m_fv    = 1'b1;
        m_stale = 1'b0;
        m_seen  = '0;
      end
    end else if (m_seen != 0) begin
      m_idle++;
      if (m_idle == T) begin
        m_seen  = '0;
        m_stale = 1'b1;
        m_idle  = 0;
      end
    end
    if ({an_in, seg_in} != m_last) m_run = 1;
    else if (m_run < 1000) m_run++;
    m_last    = {an_in, seg_in};
    m_acc     = (m_run == S);
    m_acc_idx = an_in;
    m_acc_nib = seg_in;
  endtask

  // Apply a pair for one cycle, advance the model, compare all outputs.
  task automatic step(input logic [2:0] a, input logic [3:0] s);
    an_in  = a;
    seg_in = s;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (frame_valid === 1'b1) begin
      fv_count++;
      fv_cyc = cyc;
      fv_dc  = data_changed;
    end
    check("data_out", data_out, m_data);
    check("frame_valid", {31'b0, frame_valid}, {31'b0, m_fv});
    check("data_changed", {31'b0, data_changed}, {31'b0, m_dc});
    check("stale", {31'b0, stale}, {31'b0, m_stale});
  endtask

  task automatic hold(input logic [2:0] a, input logic [3:0] s, input int n);
    for (int k = 0; k < n; k++) step(a, s);
  endtask

  task automatic scan(input logic [31:0] w, input int first, input int last, input int n);
    for (int i = first; i <= last; i++) hold(3'(i), w[4*i +: 4], n);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, data_out, 32'h0);
    check({tag, "_fv"}, {31'b0, frame_valid}, 32'h0);
    check({tag, "_dc"}, {31'b0, data_changed}, 32'h0);
    check({tag, "_stale"}, {31'b0, stale}, 32'h1);
  endtask

  initial begin
    int t7;
    int ord[8];
    logic [31:0] w;
    model_reset();
    reset  = 1'b1;
    an_in  = '0;
    seg_in = '0;

    // 1. Reset and idle.
    hold(3'd0, 4'd0, 3);
    check_reset_values("rst");
    reset = 1'b0;
    fv_count = 0;
    hold(3'd0, 4'd0, 100);
    check("idle_fv_count", fv_count, 0);
    check("idle_stale", {31'b0, stale}, 32'h1);

    // 2. First frame and its latency.
    fv_count = 0;
    scan(32'h00123456, 0, 6, 8);
    t7 = cyc;
    hold(3'd7, 4'h0, 8);
    check("f1_count", fv_count, 1);
    check("f1_latency", fv_cyc, t7 + S + 1);
    check("f1_data", data_out, 32'h00123456);
    check("f1_changed", {31'b0, fv_dc}, 32'h1);
    check("f1_stale", {31'b0, stale}, 32'h0);

    // 3. Identical frame, then a one-nibble change.
    fv_count = 0;
    scan(32'h00123456, 0, 7, 8);
    check("f2_count", fv_count, 1);
    check("f2_changed", {31'b0, fv_dc}, 32'h0);
    check("f2_data", data_out, 32'h00123456);
    fv_count = 0;
    scan(32'h00123457, 0, 7, 8);
    check("f3_count", fv_count, 1);
    check("f3_changed", {31'b0, fv_dc}, 32'h1);

    // 4. Short glitch on index 2 is ignored; the proper hold is taken.
    fv_count = 0;
    w = 32'h9E8D7401;
    scan(w, 0, 1, 8);
    hold(3'd2, 4'hF, 3);
    hold(3'd2, 4'h4, 8);
    scan(w, 3, 7, 8);
    check("glitch_count", fv_count, 1);
    check("glitch_nib2", {28'b0, data_out[11:8]}, 32'h4);
    check("glitch_data", data_out, 32'h9E8D7401);
    fv_count = 0;
    scan(32'h11111111, 0, 1, 8);
    hold(3'd2, 4'hF, 3);
    scan(32'h11111111, 3, 7, 8);
    hold(3'd7, 4'h1, 80);
    check("missing_count", fv_count, 0);
    check("missing_data", data_out, 32'h9E8D7401);

    // 5. Partial frame times out; the next full frame recovers.
    fv_count = 0;
    scan(32'h22222222, 0, 4, 8);
    hold(3'd4, 4'h2, 80);
    check("to_stale", {31'b0, stale}, 32'h1);
    check("to_count", fv_count, 0);
    check("to_data", data_out, 32'h9E8D7401);
    scan(32'h00235959, 0, 7, 8);
    check("rec_count", fv_count, 1);
    check("rec_data", data_out, 32'h00235959);
    check("rec_stale", {31'b0, stale}, 32'h0);

    // 6. Arbitrary order with an overwrite of index 3.
    fv_count = 0;
    w = 32'hFEDCBA98;
    hold(3'd7, w[31:28], 8);
    hold(3'd3, w[15:12], 8);
    hold(3'd3, 4'h7, 8);
    scan(w, 0, 2, 8);
    scan(w, 4, 6, 8);
    check("order_count", fv_count, 1);
    check("order_nib3", {28'b0, data_out[15:12]}, 32'h7);
    check("order_data", data_out, 32'hFEDC7A98);

    // Reset mid-frame: nothing published, everything back to reset values.
    fv_count = 0;
    scan(32'h13579BDF, 0, 3, 8);
    reset = 1'b1;
    hold(3'd3, 4'h9, 2);
    check_reset_values("midrst");
    reset = 1'b0;
    hold(3'd3, 4'h9, 20);
    check("midrst_count", fv_count, 0);

    // Random frames: random words, order, hold lengths and glitches.
    for (int f = 0; f < 14; f++) begin
      w = $urandom;
      for (int i = 0; i < 8; i++) ord[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j, tmp;
        j = int'($urandom_range(0, i));
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      for (int i = 0; i < ((f % 5 == 4) ? 5 : 8); i++) begin
        if ($urandom_range(0, 3) == 0)
          hold(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               int'($urandom_range(1, S - 1)));
        hold(3'(ord[i]), w[4*ord[i] +: 4], int'($urandom_range(S, S + 6)));
      end
      if (f % 5 == 4) hold(3'(ord[4]), w[4*ord[4] +: 4], T + 10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
